// File: rtl/rom_burst_arbiter.sv
// Round-robin arbiter sharing one async single-port ROM between two burst-read requesters.
// Latency: grant pulse one cycle after the request edge; first word registered one edge later, then 1 word/cycle.
// Backpressure: DREADY low holds DOUT/DLAST/ROM_ADDR; the next word is captured only when the output slot frees.
module rom_burst_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int LEN_WIDTH  = 3
) (
    input  logic                  CLK,
    input  logic                  N_RESET,
    input  logic                  REQ0,
    input  logic [ADDR_WIDTH-1:0] ADDR0,
    input  logic [LEN_WIDTH-1:0]  LEN0,
    output logic                  GNT0,
    input  logic                  REQ1,
    input  logic [ADDR_WIDTH-1:0] ADDR1,
    input  logic [LEN_WIDTH-1:0]  LEN1,
    output logic                  GNT1,
    output logic [ADDR_WIDTH-1:0] ROM_ADDR,
    input  logic [DATA_WIDTH-1:0] ROM_Q,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  DVALID,
    input  logic                  DREADY,
    output logic                  DLAST,
    output logic                  DOWNER,
    output logic                  BUSY
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]           state;
    logic                 pri;
    logic [LEN_WIDTH-1:0] rem;
    logic                 win;
    logic                 slot_free;
    logic                 last_word;
    logic                 out_done;

    // Winner: a lone requester always wins; on a tie the priority pointer decides.
    always_comb begin
        win = 1'b0;
        if (REQ0 && REQ1) begin
            win = pri;
        end else if (REQ1) begin
            win = 1'b1;
        end
    end

    // Output slot is free when empty or being consumed this edge; the final word
    // is the one captured while no further words remain.
    always_comb begin
        slot_free = !DVALID || DREADY;
        last_word = (rem == '0);
        out_done  = DVALID && DREADY;
    end

    // Control FSM: arbitration in IDLE, burst fetch in READ, last-word handoff in DRAIN.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            state  <= IDLE;
            pri    <= 1'b0;
            GNT0   <= 1'b0;
            GNT1   <= 1'b0;
            DOWNER <= 1'b0;
            BUSY   <= 1'b0;
        end else begin
            GNT0 <= 1'b0;
            GNT1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (REQ0 || REQ1) begin
                        state  <= READ;
                        BUSY   <= 1'b1;
                        DOWNER <= win;
                        GNT0   <= !win;
                        GNT1   <= win;
                    end
                end
                READ: begin
                    if (slot_free && last_word) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Loser of the last tie is favoured next time.
                    if (out_done) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        pri   <= ~DOWNER;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

    // Address/length bookkeeping: load on grant, advance (wrapping) per captured word.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            ROM_ADDR <= '0;
            rem      <= '0;
        end else begin
            if (state == IDLE) begin
                if (REQ0 || REQ1) begin
                    ROM_ADDR <= win ? ADDR1 : ADDR0;
                    rem      <= win ? LEN1 : LEN0;
                end
            end else if (state == READ) begin
                if (slot_free && !last_word) begin
                    ROM_ADDR <= ROM_ADDR + 1'b1;
                    rem      <= rem - 1'b1;
                end
            end
        end
    end

    // Output register: capture ROM data when the slot frees, clear after the final handshake.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            DOUT   <= '0;
            DVALID <= 1'b0;
            DLAST  <= 1'b0;
        end else begin
            if (state == READ) begin
                if (slot_free) begin
                    DOUT   <= ROM_Q;
                    DVALID <= 1'b1;
                    DLAST  <= last_word;
                end
            end else if (state == DRAIN) begin
                if (out_done) begin
                    DVALID <= 1'b0;
                    DLAST  <= 1'b0;
                end
            end else begin
                DVALID <= 1'b0;
                DLAST  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Bench for rom_burst_arbiter: transaction-level model plus directed and random stimulus.
// Model is advanced on each rising edge from sampled inputs; outputs compared on the falling edge.
// Consumer backpressure is exercised both in a directed stall and with random DREADY.
module tb_rom_burst_arbiter;

    logic       CLK = 1'b0;
    logic       N_RESET;
    logic       REQ0, REQ1;
    logic [2:0] ADDR0, ADDR1;
    logic [2:0] LEN0, LEN1;
    logic       GNT0, GNT1;
    logic [2:0] ROM_ADDR;
    logic [7:0] ROM_Q;
    logic [7:0] DOUT;
    logic       DVALID, DREADY, DLAST, DOWNER, BUSY;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    function automatic logic [7:0] rom_word(input logic [2:0] a);
        case (a)
            3'd0: return 8'hAA;
            3'd1: return 8'hF0;
            3'd2: return 8'h0F;
            3'd3: return 8'hCC;
            3'd4: return 8'hE7;
            3'd5: return 8'h18;
            3'd6: return 8'hB7;
            default: return 8'hED;
        endcase
    endfunction

    assign ROM_Q = rom_word(ROM_ADDR);

    rom_burst_arbiter dut (
        .CLK(CLK), .N_RESET(N_RESET),
        .REQ0(REQ0), .ADDR0(ADDR0), .LEN0(LEN0), .GNT0(GNT0),
        .REQ1(REQ1), .ADDR1(ADDR1), .LEN1(LEN1), .GNT1(GNT1),
        .ROM_ADDR(ROM_ADDR), .ROM_Q(ROM_Q),
        .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY), .DLAST(DLAST),
        .DOWNER(DOWNER), .BUSY(BUSY)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Transaction-level model: a burst is (owner, start, word count); progress is
    // tracked as the number of words captured so far and whether one is on display.
    bit m_idle, m_valid, m_pri, m_owner, m_gnt0, m_gnt1;
    int m_cap, m_n, m_start, m_eaddr;

    // Logs of what the DUT actually delivered, for literal checks in directed tests.
    int acc_dat[$];
    int acc_last[$];
    int acc_own[$];
    int gnt_log[$];
    int cap_addr[$];

    always @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            m_idle = 1; m_valid = 0; m_pri = 0; m_owner = 0;
            m_gnt0 = 0; m_gnt1 = 0; m_cap = 0; m_n = 0; m_start = 0; m_eaddr = 0;
        end else begin
            if (DVALID && DREADY) begin
                acc_dat.push_back(int'(DOUT));
                acc_last.push_back(int'(DLAST));
                acc_own.push_back(int'(DOWNER));
            end
            if (GNT0) gnt_log.push_back(0);
            if (GNT1) gnt_log.push_back(1);
            m_gnt0 = 0;
            m_gnt1 = 0;
            if (m_idle) begin
                if (REQ0 || REQ1) begin
                    m_owner = (REQ0 && REQ1) ? m_pri : REQ1;
                    m_start = m_owner ? int'(ADDR1) : int'(ADDR0);
                    m_n     = (m_owner ? int'(LEN1) : int'(LEN0)) + 1;
                    m_cap   = 0;
                    m_idle  = 0;
                    if (m_owner) m_gnt1 = 1; else m_gnt0 = 1;
                end
            end else if (m_valid && DREADY && m_cap == m_n) begin
                m_valid = 0;
                m_idle  = 1;
                m_pri   = ~m_owner;
            end else if (!m_valid || DREADY) begin
                cap_addr.push_back(int'(ROM_ADDR));
                m_cap   = m_cap + 1;
                m_valid = 1;
            end
            if (!m_idle)
                m_eaddr = (m_start + ((m_cap < m_n - 1) ? m_cap : m_n - 1)) % 8;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge CLK) begin
        if (N_RESET) begin
            chk("busy", BUSY, !m_idle);
            chk("gnt0", GNT0, m_gnt0);
            chk("gnt1", GNT1, m_gnt1);
            chk("dvalid", DVALID, m_valid);
            chk("dlast", DLAST, m_valid && (m_cap == m_n));
            chk("downer", DOWNER, m_owner);
            chk("rom_addr", ROM_ADDR, m_eaddr);
            if (m_valid) chk("dout", DOUT, rom_word(3'(m_start + m_cap - 1)));
        end
    end

    function automatic int qd(int i); return (i < acc_dat.size())  ? acc_dat[i]  : -1; endfunction
    function automatic int ql(int i); return (i < acc_last.size()) ? acc_last[i] : -1; endfunction
    function automatic int qo(int i); return (i < acc_own.size())  ? acc_own[i]  : -1; endfunction
    function automatic int qg(int i); return (i < gnt_log.size())  ? gnt_log[i]  : -1; endfunction
    function automatic int qa(int i); return (i < cap_addr.size()) ? cap_addr[i] : -1; endfunction

    task automatic clear_logs();
        acc_dat.delete(); acc_last.delete(); acc_own.delete();
        gnt_log.delete(); cap_addr.delete();
    endtask

    task automatic do_reset();
        N_RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            REQ0 = 1'($urandom); REQ1 = 1'($urandom);
            ADDR0 = 3'($urandom); ADDR1 = 3'($urandom);
            LEN0 = 3'($urandom); LEN1 = 3'($urandom);
            DREADY = 1'($urandom);
            @(negedge CLK);
            chk("rst_gnt0", GNT0, 0);
            chk("rst_gnt1", GNT1, 0);
            chk("rst_rom_addr", ROM_ADDR, 0);
            chk("rst_dout", DOUT, 0);
            chk("rst_dvalid", DVALID, 0);
            chk("rst_dlast", DLAST, 0);
            chk("rst_downer", DOWNER, 0);
            chk("rst_busy", BUSY, 0);
        end
        REQ0 = 0; REQ1 = 0; DREADY = 0;
        @(posedge CLK);
        #2 N_RESET = 1'b1;
    endtask

    task automatic issue(input int who, input int a, input int l);
        bit got = 0;
        if (who == 0) begin REQ0 = 1; ADDR0 = 3'(a); LEN0 = 3'(l); end
        else          begin REQ1 = 1; ADDR1 = 3'(a); LEN1 = 3'(l); end
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if ((who == 0) ? GNT0 : GNT1) begin got = 1; break; end
        end
        if (who == 0) REQ0 = 0; else REQ1 = 0;
        chk("grant_timeout", got, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(posedge CLK); #1;
            if (!BUSY) break;
        end
        chk("idle_timeout", BUSY, 0);
    endtask

    task automatic wait_word(input int w, input string name);
        bit seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK); #1;
            if (DVALID && DOUT == 8'(w)) begin seen = 1; break; end
        end
        chk(name, seen, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end on its own");
        $fatal(1);
    end

    initial begin
        N_RESET = 0; REQ0 = 0; REQ1 = 0; ADDR0 = 0; ADDR1 = 0;
        LEN0 = 0; LEN1 = 0; DREADY = 0;
        do_reset();

        // Single burst from requester 0.
        clear_logs(); DREADY = 1;
        issue(0, 2, 2);
        wait_idle();
        chk("single_cnt", acc_dat.size(), 3);
        chk("single_d0", qd(0), 'h0F);
        chk("single_d1", qd(1), 'hCC);
        chk("single_d2", qd(2), 'hE7);
        chk("single_l0", ql(0), 0);
        chk("single_l1", ql(1), 0);
        chk("single_l2", ql(2), 1);
        chk("single_own", qo(2), 0);
        chk("single_gnts", gnt_log.size(), 1);

        // Wrap-around from requester 1.
        clear_logs();
        issue(1, 6, 3);
        wait_idle();
        chk("wrap_d0", qd(0), 'hB7);
        chk("wrap_d1", qd(1), 'hED);
        chk("wrap_d2", qd(2), 'hAA);
        chk("wrap_d3", qd(3), 'hF0);
        chk("wrap_own", qo(0), 1);
        chk("wrap_a0", qa(0), 6);
        chk("wrap_a1", qa(1), 7);
        chk("wrap_a2", qa(2), 0);
        chk("wrap_a3", qa(3), 1);

        // Round-robin with both requesters held.
        do_reset();
        clear_logs(); DREADY = 1;
        REQ0 = 1; ADDR0 = 3; LEN0 = 0;
        REQ1 = 1; ADDR1 = 4; LEN1 = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge CLK); #1;
            if (gnt_log.size() >= 4) break;
        end
        REQ0 = 0; REQ1 = 0;
        wait_idle();
        chk("rr_g0", qg(0), 0);
        chk("rr_g1", qg(1), 1);
        chk("rr_g2", qg(2), 0);
        chk("rr_g3", qg(3), 1);
        chk("rr_d0", qd(0), 'hCC);
        chk("rr_d1", qd(1), 'hE7);
        chk("rr_d2", qd(2), 'hCC);
        chk("rr_d3", qd(3), 'hE7);

        // Backpressure after the second word.
        clear_logs();
        issue(0, 0, 4);
        wait_word('hF0, "bp_second_word");
        DREADY = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("bp_hold_dout", DOUT, 'hF0);
            chk("bp_hold_addr", ROM_ADDR, 2);
        end
        @(posedge CLK); #1 DREADY = 1;
        wait_idle();
        chk("bp_cnt", acc_dat.size(), 5);
        chk("bp_d0", qd(0), 'hAA);
        chk("bp_d1", qd(1), 'hF0);
        chk("bp_d2", qd(2), 'h0F);
        chk("bp_d3", qd(3), 'hCC);
        chk("bp_d4", qd(4), 'hE7);

        // Reset pulsed while the third word of an 8-word burst is on display.
        clear_logs();
        issue(0, 0, 7);
        wait_word('h0F, "mid_third_word");
        #2 N_RESET = 0;
        #1;
        chk("mid_rst_dvalid", DVALID, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_dlast", DLAST, 0);
        @(posedge CLK);
        #2 N_RESET = 1;
        @(posedge CLK); #1;
        clear_logs();
        issue(1, 5, 0);
        wait_idle();
        chk("mid_cnt", acc_dat.size(), 1);
        chk("mid_d0", qd(0), 'h18);
        chk("mid_l0", ql(0), 1);
        chk("mid_own", qo(0), 1);

        // Random requests and consumer stalls against the model.
        for (int c = 0; c < 600; c++) begin
            @(posedge CLK); #1;
            DREADY = ($urandom_range(0, 3) != 0);
            if (GNT0) REQ0 = 0;
            else if (!REQ0 && $urandom_range(0, 3) == 0) begin
                REQ0 = 1; ADDR0 = 3'($urandom); LEN0 = 3'($urandom);
            end
            if (GNT1) REQ1 = 0;
            else if (!REQ1 && $urandom_range(0, 3) == 0) begin
                REQ1 = 1; ADDR1 = 3'($urandom); LEN1 = 3'($urandom);
            end
        end
        REQ0 = 0; REQ1 = 0; DREADY = 1;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
